obi_apb_bridge: RTL and testbench

OBI_APB_BRIDGE -- requirements
Module: obi_apb_bridge

---
 rtl/obi_apb_pkg.sv | 15 +
 rtl/apb_timeout_cnt.sv | 36 +++
 rtl/obi_apb_bridge.sv | 154 +++++++++++++++
 tb/tb_obi_apb_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/obi_apb_pkg.sv
// rtl/obi_apb_pkg.sv - shared types and constants for the OBI-to-APB bridge
package obi_apb_pkg;

    // Bridge sequencing: accept on OBI, run APB setup/access, hold OBI response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Default number of ACCESS cycles allowed without PREADY.
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase cycle counter with expiry flag
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : count this cycle (bridge is in ACCESS)
//   clear        : return the count to zero (bridge is outside ACCESS)
//   expired      : current ACCESS cycle is the LIMIT-th one; never set when LIMIT is 0
module apb_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    // The count holds the number of ACCESS cycles already completed, so the
    // LIMIT-th cycle is the one where the count equals LIMIT-1.
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (LIMIT > 0) && enable && (count_q == LAST);

endmodule

// File: rtl/obi_apb_bridge.sv
// rtl/obi_apb_bridge.sv - single-outstanding OBI subordinate to APB requester bridge
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   obi_req/gnt/gntpar      : OBI A-channel handshake (gntpar = ~gnt)
//   obi_addr/we/be/wdata/aid: OBI request fields, captured on req&gnt
//   obi_rvalid/rvalidpar    : OBI R-channel valid (rvalidpar = ~rvalid)
//   obi_rready              : OBI R-channel ready
//   obi_rdata/rid/err       : OBI response fields, stable while rvalid
//   APB_P*                  : APB requester side
module obi_apb_bridge
    import obi_apb_pkg::*;
#(
    parameter int OBI_AW         = 32,
    parameter int OBI_DW         = 32,
    parameter int OBI_IDW        = 1,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                obi_req,
    output logic                obi_gnt,
    output logic                obi_gntpar,
    input  logic [OBI_AW-1:0]   obi_addr,
    input  logic                obi_we,
    input  logic [OBI_DW/8-1:0] obi_be,
    input  logic [OBI_DW-1:0]   obi_wdata,
    input  logic [OBI_IDW-1:0]  obi_aid,
    output logic                obi_rvalid,
    output logic                obi_rvalidpar,
    input  logic                obi_rready,
    output logic [OBI_DW-1:0]   obi_rdata,
    output logic [OBI_IDW-1:0]  obi_rid,
    output logic                obi_err,
    output logic [OBI_AW-1:0]   APB_PADDR,
    output logic                APB_PWRITE,
    output logic [OBI_DW-1:0]   APB_PWDATA,
    output logic [OBI_DW/8-1:0] APB_PSTRB,
    output logic                APB_PSEL,
    output logic                APB_PENABLE,
    input  logic [OBI_DW-1:0]   APB_PRDATA,
    input  logic                APB_PREADY,
    input  logic                APB_PSLVERR
);

    state_t state_q, state_d;

    logic [OBI_AW-1:0]   addr_q;
    logic                we_q;
    logic [OBI_DW/8-1:0] be_q;
    logic [OBI_DW-1:0]   wdata_q;
    logic [OBI_IDW-1:0]  aid_q;
    logic [OBI_DW-1:0]   rdata_q;
    logic                err_q;
    logic                in_access;
    logic                expired;

    assign in_access = (state_q == ST_ACCESS);

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (in_access),
        .clear   (!in_access),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        obi_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                obi_gnt = obi_req;
                if (obi_req) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins a tie with the timeout; both exits land in RESP.
                if (APB_PREADY || expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (obi_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request fields are only loaded on an accepted request, so the APB
    // request stays stable across SETUP and ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            aid_q   <= '0;
        end else if ((state_q == ST_IDLE) && obi_req) begin
            addr_q  <= obi_addr;
            we_q    <= obi_we;
            be_q    <= obi_be;
            wdata_q <= obi_wdata;
            aid_q   <= obi_aid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (in_access) begin
            if (APB_PREADY) begin
                rdata_q <= we_q ? '0 : APB_PRDATA;
                err_q   <= APB_PSLVERR;
            end else if (expired) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign obi_gntpar    = ~obi_gnt;
    assign obi_rvalid    = (state_q == ST_RESP);
    assign obi_rvalidpar = ~obi_rvalid;
    assign obi_rdata     = rdata_q;
    assign obi_err       = err_q;
    assign obi_rid       = aid_q;

    assign APB_PSEL    = (state_q == ST_SETUP) || in_access;
    assign APB_PENABLE = in_access;
    assign APB_PADDR   = addr_q;
    assign APB_PWRITE  = we_q;
    assign APB_PWDATA  = wdata_q;
    assign APB_PSTRB   = we_q ? be_q : '0;

endmodule

// File: tb/tb_obi_apb_bridge.sv
// tb/tb_obi_apb_bridge.sv - directed self-checking bench for obi_apb_bridge
module tb_obi_apb_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        obi_req;
    logic        obi_gnt;
    logic        obi_gntpar;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic [0:0]  obi_aid;
    logic        obi_rvalid;
    logic        obi_rvalidpar;
    logic        obi_rready;
    logic [31:0] obi_rdata;
    logic [0:0]  obi_rid;
    logic        obi_err;
    logic [31:0] apb_paddr;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic        apb_psel;
    logic        apb_penable;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    obi_apb_bridge #(
        .OBI_AW         (32),
        .OBI_DW         (32),
        .OBI_IDW        (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .obi_req       (obi_req),
        .obi_gnt       (obi_gnt),
        .obi_gntpar    (obi_gntpar),
        .obi_addr      (obi_addr),
        .obi_we        (obi_we),
        .obi_be        (obi_be),
        .obi_wdata     (obi_wdata),
        .obi_aid       (obi_aid),
        .obi_rvalid    (obi_rvalid),
        .obi_rvalidpar (obi_rvalidpar),
        .obi_rready    (obi_rready),
        .obi_rdata     (obi_rdata),
        .obi_rid       (obi_rid),
        .obi_err       (obi_err),
        .APB_PADDR     (apb_paddr),
        .APB_PWRITE    (apb_pwrite),
        .APB_PWDATA    (apb_pwdata),
        .APB_PSTRB     (apb_pstrb),
        .APB_PSEL      (apb_psel),
        .APB_PENABLE   (apb_penable),
        .APB_PRDATA    (apb_prdata),
        .APB_PREADY    (apb_pready),
        .APB_PSLVERR   (apb_pslverr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction starting in the current cycle (just after a rising
    // edge); returns just after the rising edge that follows the accepted response.
    task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata, input logic aid,
                       input int wait_n, input logic [31:0] prdata, input logic slverr,
                       input int hold_n, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_access);
        int          cnt;
        logic        stable;
        logic [3:0]  exp_strb;
        exp_strb   = we ? be : 4'h0;
        obi_req    = 1'b1;
        obi_addr   = addr;
        obi_we     = we;
        obi_be     = be;
        obi_wdata  = wdata;
        obi_aid    = aid;
        obi_rready = (hold_n == 0);
        apb_pready = 1'b0;
        @(negedge clk);
        check({tag, "_grant"}, {obi_gnt, obi_gntpar, obi_rvalid}, {1'b1, 1'b0, 1'b0});
        step();
        obi_req   = 1'b0;
        obi_addr  = ~addr;
        obi_we    = ~we;
        obi_be    = ~be;
        obi_wdata = ~wdata;
        obi_aid   = ~aid;
        @(negedge clk);
        check({tag, "_setup"}, {apb_psel, apb_penable, apb_pwrite, apb_pstrb, apb_paddr, apb_pwdata},
              {1'b1, 1'b0, we, exp_strb, addr, wdata});
        cnt    = 0;
        stable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            apb_pready  = (cnt == wait_n);
            apb_prdata  = prdata;
            apb_pslverr = slverr;
            @(negedge clk);
            if (!(apb_psel && apb_penable)) break;
            if (apb_paddr != addr || apb_pwdata != wdata || apb_pwrite != we || apb_pstrb != exp_strb)
                stable = 1'b0;
            cnt++;
        end
        apb_pready = 1'b0;
        check({tag, "_access_cycles"}, 64'(cnt), 64'(exp_access));
        check({tag, "_apb_stable"}, {63'd0, stable}, 64'd1);
        check({tag, "_resp"}, {obi_rvalid, obi_rvalidpar, apb_psel, apb_penable, obi_err, obi_rid, obi_rdata},
              {1'b1, 1'b0, 1'b0, 1'b0, exp_err, aid, exp_rdata});
        for (int h = 1; h <= hold_n; h++) begin
            step();
            obi_rready = (h == hold_n);
            obi_req    = (h < hold_n);
            @(negedge clk);
            check({tag, "_hold"}, {obi_rvalid, obi_gnt, obi_err, obi_rid, obi_rdata},
                  {1'b1, 1'b0, exp_err, aid, exp_rdata});
        end
        step();
        obi_req    = 1'b0;
        obi_rready = 1'b0;
    endtask

    initial begin
        int rv_seen;
        reset_n     = 1'b0;
        obi_req     = 1'b0;
        obi_addr    = 32'h0;
        obi_we      = 1'b0;
        obi_be      = 4'h0;
        obi_wdata   = 32'h0;
        obi_aid     = 1'b0;
        obi_rready  = 1'b0;
        apb_prdata  = 32'h0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_ctrl", {apb_psel, apb_penable, apb_pwrite, obi_rvalid, obi_rvalidpar, obi_err, obi_gnt, obi_gntpar},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        check("reset_data", {apb_paddr, apb_pwdata}, 64'd0);
        check("reset_resp", {apb_pstrb, obi_rid, obi_rdata}, 64'd0);
        step();
        reset_n = 1'b1;
        step();

        // write, PREADY in first ACCESS: rvalid lands at cycle 3
        txn("wr", 32'h0105_2004, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0,
            0, 32'h5555_AAAA, 1'b0, 0, 32'h0, 1'b0, 1);
        // read issued at cycle 4 (back-to-back), PREADY after 4 wait cycles
        txn("rd_wait", 32'h0000_0040, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b1,
            4, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 5);
        // read with slave error; response held off by rready=0 for 3 cycles
        txn("rd_slverr", 32'h0000_0080, 1'b0, 4'h3, 32'h0, 1'b0,
            1, 32'hCAFE_F00D, 1'b1, 3, 32'hCAFE_F00D, 1'b1, 2);
        // PREADY never arrives: timeout after 8 ACCESS cycles
        txn("rd_timeout", 32'h0000_00C0, 1'b0, 4'hF, 32'h0, 1'b1,
            1000, 32'hAAAA_5555, 1'b0, 0, 32'h0, 1'b1, 8);
        // partial write with slave error: rdata forced to zero
        txn("wr_part", 32'hFFFF_FFFC, 1'b1, 4'h5, 32'h0123_4567, 1'b1,
            2, 32'h7777_7777, 1'b1, 1, 32'h0, 1'b1, 3);

        // reset in the middle of ACCESS
        obi_req   = 1'b1;
        obi_addr  = 32'h0000_1000;
        obi_we    = 1'b1;
        obi_be    = 4'hF;
        obi_wdata = 32'h1111_2222;
        obi_aid   = 1'b1;
        obi_rready = 1'b1;
        step();
        obi_req = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_pre_access", {apb_psel, apb_penable}, {1'b1, 1'b1});
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_ctrl", {apb_psel, apb_penable, apb_pwrite, obi_rvalid, obi_rvalidpar, obi_err, obi_gntpar},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        check("rst_async_data", {apb_paddr, apb_pwdata}, 64'd0);
        check("rst_async_resp", {apb_pstrb, obi_rid, obi_rdata}, 64'd0);
        step();
        reset_n    = 1'b1;
        apb_pready = 1'b1;
        rv_seen    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (obi_rvalid || apb_psel) rv_seen++;
            step();
        end
        check("rst_no_resp", 64'(rv_seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
